lfsr_checker: RTL and testbench



---
 rtl/lfsr_checker.sv | 186 ++++++++++++++++++
 tb/tb_lfsr_checker.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_checker.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_checker
// Purpose  : Receive-side integrity checker for a 4-bit XNOR LFSR traffic
//            stream. It self-synchronises a local copy of the LFSR from the
//            incoming words. Once locked, it flags every accepted word that
//            differs from the expected next value. It keeps saturating error
//            and word counters.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous active-high reset
//   in_valid   in   1      in_data valid this cycle
//   in_data    in   4      received LFSR word
//   in_ready   out  1      checker accepts a word this cycle (low in CLEAR)
//   clr_cnt    in   1      synchronous clear of err_count / word_count
//   locked     out  1      high while locked onto the stream
//   err_pulse  out  1      one-cycle pulse per mismatching word while locked
//   err_count  out  CNT_W  saturating mismatch count while locked
//   word_count out  CNT_W  saturating count of words accepted while locked
//   state      out  2      00 HUNT, 01 LOCKED, 10 CLEAR
// ============================================================================
module lfsr_checker #(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [3:0]       in_data,
  output logic             in_ready,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] word_count,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'b00,
    ST_LOCKED = 2'b01,
    ST_CLEAR  = 2'b10
  } state_t;

  localparam logic [3:0]       LOCK_TARGET = 4'(LOCK_COUNT);
  localparam logic [3:0]       LOSS_TARGET = 4'(LOSS_COUNT);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [3:0]       LOCKUP      = 4'b1111;

  // Same XNOR feedback as the traffic source.
  function automatic logic [3:0] lfsr_next(input logic [3:0] x);
    return {x[2:0], ~(x[3] ^ x[0])};
  endfunction

  state_t           state_q, state_d;
  logic [3:0]       ref_q, ref_d;
  logic             seeded_q, seeded_d;
  logic [3:0]       match_cnt_q, match_cnt_d;
  logic [3:0]       miss_cnt_q, miss_cnt_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [CNT_W-1:0] word_count_q, word_count_d;
  logic             in_ready_q, in_ready_d;

  logic             accept;
  logic [3:0]       expected;

  assign accept   = in_valid & in_ready_q;
  assign expected = lfsr_next(ref_q);

  always_comb begin
    state_d      = state_q;
    ref_d        = ref_q;
    seeded_d     = seeded_q;
    match_cnt_d  = match_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    locked_d     = locked_q;
    err_pulse_d  = 1'b0;
    err_count_d  = err_count_q;
    word_count_d = word_count_q;
    in_ready_d   = 1'b1;

    if (accept) begin
      if (!locked_q) begin
        // Hunting: build a run of consecutive legal transitions.
        if (in_data == LOCKUP) begin
          // The lock-up word can never be part of the sequence, so it
          // also discards any seed taken so far.
          seeded_d    = 1'b0;
          match_cnt_d = 4'd0;
        end else if (!seeded_q || (in_data != expected)) begin
          ref_d       = in_data;
          seeded_d    = 1'b1;
          match_cnt_d = 4'd0;
        end else begin
          ref_d       = in_data;
          match_cnt_d = match_cnt_q + 4'd1;
          if (match_cnt_d == LOCK_TARGET) begin
            locked_d   = 1'b1;
            miss_cnt_d = 4'd0;
          end
        end
      end else begin
        // Locked: the local LFSR free-runs on accepted words so that a
        // corrupted word cannot pull the alignment off the true sequence.
        ref_d = expected;
        if (word_count_q != CNT_MAX) begin
          word_count_d = word_count_q + CNT_ONE;
        end
        if (in_data == expected) begin
          miss_cnt_d = 4'd0;
        end else begin
          err_pulse_d = 1'b1;
          if (err_count_q != CNT_MAX) begin
            err_count_d = err_count_q + CNT_ONE;
          end
          miss_cnt_d = miss_cnt_q + 4'd1;
          if (miss_cnt_d == LOSS_TARGET) begin
            locked_d    = 1'b0;
            seeded_d    = 1'b0;
            match_cnt_d = 4'd0;
          end
        end
      end
    end

    // Counter clear wins over any increment from a word taken this edge.
    // The word itself is still checked, so nothing is lost; CLEAR then
    // holds in_ready low for the following cycle.
    if (clr_cnt) begin
      err_count_d  = '0;
      word_count_d = '0;
      in_ready_d   = 1'b0;
    end

    // CLEAR is an overlay on the lock status. locked_q remembers the state
    // to return to, so no separate "prior state" register is needed.
    if (clr_cnt) begin
      state_d = ST_CLEAR;
    end else if (locked_d) begin
      state_d = ST_LOCKED;
    end else begin
      state_d = ST_HUNT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_HUNT;
      ref_q        <= 4'd0;
      seeded_q     <= 1'b0;
      match_cnt_q  <= 4'd0;
      miss_cnt_q   <= 4'd0;
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_count_q  <= '0;
      word_count_q <= '0;
      in_ready_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ref_q        <= ref_d;
      seeded_q     <= seeded_d;
      match_cnt_q  <= match_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      locked_q     <= locked_d;
      err_pulse_q  <= err_pulse_d;
      err_count_q  <= err_count_d;
      word_count_q <= word_count_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign locked     = locked_q;
  assign err_pulse  = err_pulse_q;
  assign err_count  = err_count_q;
  assign word_count = word_count_q;
  assign state      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_lfsr_checker
// Purpose  : Self-checking bench for lfsr_checker. Two instances share one
//            stimulus stream: default parameters, and a narrow-counter
//            instance (CNT_W=2, LOSS_COUNT=15) that exercises saturation.
//            A reference model built on the LFSR sequence table predicts
//            every cycle's outputs into a queue. A monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lfsr_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_data;
  logic       clr_cnt;

  logic        a_ready, a_locked, a_pulse;
  logic [15:0] a_err, a_words;
  logic [1:0]  a_state;
  logic        b_ready, b_locked, b_pulse;
  logic [1:0]  b_err, b_words;
  logic [1:0]  b_state;

  lfsr_checker #(.LOCK_COUNT(4), .LOSS_COUNT(3), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(a_ready), .clr_cnt(clr_cnt), .locked(a_locked),
    .err_pulse(a_pulse), .err_count(a_err), .word_count(a_words),
    .state(a_state)
  );

  lfsr_checker #(.LOCK_COUNT(4), .LOSS_COUNT(15), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(b_ready), .clr_cnt(clr_cnt), .locked(b_locked),
    .err_pulse(b_pulse), .err_count(b_err), .word_count(b_words),
    .state(b_state)
  );

  always #5 clk = ~clk;

  // The LFSR sequence as listed, period 15.
  logic [3:0] seq_tab [15] = '{4'b0000, 4'b0001, 4'b0010, 4'b0101, 4'b1010,
                               4'b0100, 4'b1001, 4'b0011, 4'b0110, 4'b1101,
                               4'b1011, 4'b0111, 4'b1110, 4'b1100, 4'b1000};

  function automatic int seq_pos(input logic [3:0] x);
    for (int i = 0; i < 15; i++) if (seq_tab[i] == x) return i;
    return -1;
  endfunction

  function automatic logic [3:0] seq_next(input logic [3:0] x);
    return seq_tab[(seq_pos(x) + 1) % 15];
  endfunction

  // ---------------- reference model (index 0 = inst A, 1 = inst B) -------
  int         loss_n [2] = '{3, 15};
  int         max_c  [2] = '{65535, 3};
  localparam int LOCK_N = 4;

  bit         m_ready;
  bit         m_clr;
  bit         m_locked [2];
  bit         m_seeded [2];
  bit         m_pulse  [2];
  logic [3:0] m_ref    [2];
  int         m_match  [2];
  int         m_miss   [2];
  int         m_err    [2];
  int         m_words  [2];

  typedef struct {
    int rdy;
    int lk0, ep0, st0, ec0, wc0;
    int lk1, ep1, st1, ec1, wc1;
  } exp_t;

  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_ready = 0;
    m_clr   = 0;
    for (int k = 0; k < 2; k++) begin
      m_locked[k] = 0; m_seeded[k] = 0; m_pulse[k] = 0; m_ref[k] = 4'd0;
      m_match[k]  = 0; m_miss[k]   = 0; m_err[k]   = 0; m_words[k] = 0;
    end
  endtask

  function automatic int m_state(input int k);
    return m_clr ? 2 : (m_locked[k] ? 1 : 0);
  endfunction

  // One clock edge of the behavioural model, then queue the prediction.
  task automatic model_step(input bit v, input logic [3:0] d, input bit c);
    bit   acc;
    exp_t e;
    acc = v && m_ready;
    for (int k = 0; k < 2; k++) begin
      m_pulse[k] = 0;
      if (acc && !m_locked[k]) begin
        if (d == 4'b1111) begin
          m_seeded[k] = 0; m_match[k] = 0;
        end else if (m_seeded[k] && d == seq_next(m_ref[k])) begin
          m_ref[k] = d;
          m_match[k]++;
          if (m_match[k] == LOCK_N) begin
            m_locked[k] = 1; m_miss[k] = 0;
          end
        end else begin
          m_ref[k] = d; m_seeded[k] = 1; m_match[k] = 0;
        end
      end else if (acc) begin
        m_ref[k]   = seq_next(m_ref[k]);
        m_words[k] = (m_words[k] < max_c[k]) ? m_words[k] + 1 : max_c[k];
        if (d == m_ref[k]) begin
          m_miss[k] = 0;
        end else begin
          m_pulse[k] = 1;
          m_err[k]   = (m_err[k] < max_c[k]) ? m_err[k] + 1 : max_c[k];
          m_miss[k]++;
          if (m_miss[k] == loss_n[k]) begin
            m_locked[k] = 0; m_seeded[k] = 0; m_match[k] = 0;
          end
        end
      end
      if (c) begin
        m_err[k] = 0; m_words[k] = 0;
      end
    end
    m_ready = !c;
    m_clr   = c;
    e.rdy = int'(m_ready);
    e.lk0 = int'(m_locked[0]); e.ep0 = int'(m_pulse[0]); e.st0 = m_state(0);
    e.ec0 = m_err[0];          e.wc0 = m_words[0];
    e.lk1 = int'(m_locked[1]); e.ep1 = int'(m_pulse[1]); e.st1 = m_state(1);
    e.ec1 = m_err[1];          e.wc1 = m_words[1];
    exp_q.push_back(e);
  endtask

  // ---------------- monitor ------------------------------------------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("a_in_ready",   int'(a_ready),  e.rdy);
        chk("b_in_ready",   int'(b_ready),  e.rdy);
        chk("a_locked",     int'(a_locked), e.lk0);
        chk("a_err_pulse",  int'(a_pulse),  e.ep0);
        chk("a_state",      int'(a_state),  e.st0);
        chk("a_err_count",  int'(a_err),    e.ec0);
        chk("a_word_count", int'(a_words),  e.wc0);
        chk("b_locked",     int'(b_locked), e.lk1);
        chk("b_err_pulse",  int'(b_pulse),  e.ep1);
        chk("b_state",      int'(b_state),  e.st1);
        chk("b_err_count",  int'(b_err),    e.ec1);
        chk("b_word_count", int'(b_words),  e.wc1);
      end
    end
  end

  // ---------------- stimulus -----------------------------------------------
  int src = 0;  // position of the next correct word in seq_tab

  task automatic cycle(input bit v, input logic [3:0] d, input bit c);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    clr_cnt  = c;
    model_step(v, d, c);
  endtask

  // Present one word until the model says it is taken (bounded).
  task automatic send(input logic [3:0] d);
    bit taken = 0;
    for (int t = 0; t < 4 && !taken; t++) begin
      taken = m_ready;
      cycle(1'b1, d, 1'b0);
    end
    if (!taken) chk("send_timeout", 0, 1);
  endtask

  // One cycle of source traffic: correct or corrupted word, optional gap.
  task automatic src_cycle(input bit v, input bit corrupt);
    logic [3:0] d;
    bit acc;
    d   = corrupt ? 4'($urandom_range(0, 15)) : seq_tab[src];
    acc = v && m_ready;
    cycle(v, d, 1'b0);
    if (acc) src = (src + 1) % 15;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_a_ready"},  int'(a_ready),  0);
    chk({tag, "_a_locked"}, int'(a_locked), 0);
    chk({tag, "_a_pulse"},  int'(a_pulse),  0);
    chk({tag, "_a_err"},    int'(a_err),    0);
    chk({tag, "_a_words"},  int'(a_words),  0);
    chk({tag, "_a_state"},  int'(a_state),  0);
    chk({tag, "_b_ready"},  int'(b_ready),  0);
    chk({tag, "_b_locked"}, int'(b_locked), 0);
    chk({tag, "_b_err"},    int'(b_err),    0);
    chk({tag, "_b_words"},  int'(b_words),  0);
  endtask

  initial begin
    int r;
    int acc_cnt;
    rst = 1; in_valid = 0; in_data = 4'd0; clr_cnt = 0;
    model_reset();
    #12;
    check_all_zero("reset");
    @(posedge clk);
    #2 rst = 0;

    // Seed and lock on the head of the sequence.
    cycle(1'b0, 4'd0, 1'b0);
    send(4'b0000); send(4'b0001); send(4'b0010); send(4'b0101); send(4'b1010);
    // One corrupted word in place of 1001; alignment must hold.
    send(4'b0100); send(4'b1111); send(4'b0011); send(4'b0110);
    // Three wrong words drop instance A back to HUNT.
    send(4'b0000); send(4'b0000); send(4'b0000);
    // Lock-up words never seed; lock after 1110.
    send(4'b1111); send(4'b1111); send(4'b0110); send(4'b1101);
    send(4'b1011); send(4'b0111); send(4'b1110);
    src = 13;

    // A few errors, then 20 correct words with random gaps, then clear.
    for (int i = 0; i < 2; i++) src_cycle(1'b1, 1'b1);
    src_cycle(1'b1, 1'b0);
    acc_cnt = 0;
    for (int i = 0; i < 200 && acc_cnt < 20; i++) begin
      r = int'($urandom_range(0, 1));
      if (r == 1 && m_ready) acc_cnt++;
      src_cycle(r[0], 1'b0);
    end
    cycle(1'b0, 4'd0, 1'b1);
    src_cycle(1'b1, 1'b0);
    src_cycle(1'b1, 1'b0);

    // Randomised traffic: gaps, clears, light then heavy corruption.
    for (int i = 0; i < 700; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 5) begin
        cycle(1'b0, 4'($urandom_range(0, 15)), 1'b1);
      end else if (r < 25) begin
        src_cycle(1'b0, 1'b0);
      end else begin
        src_cycle(1'b1, ($urandom_range(0, 99) < ((i >= 300 && i < 500) ? 45 : 8)));
      end
    end

    // Asynchronous reset in the middle of a word.
    @(negedge clk);
    in_valid = 1; in_data = seq_tab[src]; clr_cnt = 0;
    #2 rst = 1;
    #1 check_all_zero("async_rst");
    model_reset();
    @(posedge clk);
    #2 rst = 0;
    for (int i = 0; i < 40; i++) src_cycle(($urandom_range(0, 9) != 0), 1'b0);

    @(negedge clk);
    in_valid = 0; clr_cnt = 0;
    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) chk("queue_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
